// File: rtl/l1_mem_responder.sv
// l1_mem_responder: backing-memory end of the L1 data cache miss/writeback
// interface. It serves one word read or write per request with a fixed latency.
//
// Ports:
//   clk, rstn (async, active-low)
//   mem_request, mem_write_enable, mem_address[31:0], mem_write_data[31:0] : request
//   mem_ready    : one-cycle completion pulse (registered)
//   mem_response_data[31:0] : read data, held until the next read completes
//   mem_busy     : a request is in flight (WAIT or RESP)
module l1_mem_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] OOR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_request,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic        mem_ready,
    output logic [31:0] mem_response_data,
    output logic        mem_busy
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          ready_q;
    logic          busy_q;
    logic [31:0]   rdata_q;

    logic [31:0]   ram_q [DEPTH];

    logic          fire;
    logic          op_we;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [AW-1:0] op_idx;
    logic          op_oor;

    // With LATENCY=1 the RESP entry edge is the accept edge itself, so the
    // operation has to come straight from the request lines; otherwise it
    // always comes from the values latched at accept.
    assign op_we    = (state_q == IDLE) ? mem_write_enable : we_q;
    assign op_addr  = (state_q == IDLE) ? mem_address      : addr_q;
    assign op_wdata = (state_q == IDLE) ? mem_write_data   : wdata_q;
    assign op_idx   = op_addr[AW-1:0];
    assign op_oor   = |(op_addr >> AW);

    // Edge that enters RESP. It is gated by rstn so that a request held
    // during reset cannot write the array.
    assign fire = rstn &&
                  (((state_q == IDLE) && mem_request && (LATENCY == 1)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd1)));

    // The array has no reset, so its contents survive rstn.
    always_ff @(posedge clk) begin
        if (fire && op_we && !op_oor) begin
            ram_q[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_request) begin
                        addr_q  <= mem_address;
                        wdata_q <= mem_write_data;
                        we_q    <= mem_write_enable;
                        busy_q  <= 1'b1;
                        if (fire) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (fire) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (fire) begin
                ready_q <= 1'b1;
                if (!op_we) begin
                    rdata_q <= op_oor ? OOR_DATA : ram_q[op_idx];
                end
            end
        end
    end

    assign mem_ready         = ready_q;
    assign mem_response_data = rdata_q;
    assign mem_busy          = busy_q;

endmodule
